mem_access_unit: RTL

Load/store sequencer between the execute stage and the byte-addressable 64-byte data memory. It accepts one load or store request per handshake and validates func3. Aligned accesses go to the memory as a single operation. Misaligned halfword/word accesses are split into byte operations, and load data is reassembled and sign- or zero-extended before one registered response returns to the pipeline.

---
 rtl/mem_access_unit_if.sv | 31 +++
 rtl/mem_access_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Bus bundle between the execute stage, the load/store sequencer and the data memory.
// The master side is the pipeline plus memory; the slave side is the sequencer.
interface mem_access_unit_if #(parameter int ADDR_W = 6);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_func3;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_write, req_func3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_read, mem_write, mem_func3, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_func3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_read, mem_write, mem_func3, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer: aligned accesses pass through as one memory op, misaligned
// halfword/word accesses are split into byte ops and reassembled before the response.
module mem_access_unit #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic              write_q, write_d;
  logic [2:0]        func3_q, func3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [2:0]        mem_func3_q, mem_func3_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic        legal, misaligned;
  logic [1:0]  last_idx, idx_nx;
  logic [31:0] asm_data;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b100:  return {24'h0, v[7:0]};
      3'b101:  return {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

  always_comb begin
    if (bus.req_write) legal = (bus.req_func3 inside {3'b000, 3'b001, 3'b010});
    else               legal = (bus.req_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = (bus.req_func3[1:0] == 2'b01 && bus.req_addr[0]) ||
                 (bus.req_func3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    write_d     = write_q;
    func3_d     = func3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_func3_d = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    // Load byte of the current split op dropped into its little-endian lane
    asm_data = data_q;
    asm_data[{idx_q, 3'b000} +: 8] = bus.mem_rdata[7:0];
    last_idx = func3_q[1] ? 2'd3 : 2'd1;
    idx_nx   = idx_q + 2'd1;

    case (state_q)
      IDLE: if (bus.req_valid) begin
        write_d = bus.req_write;
        func3_d = bus.req_func3;
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        idx_d   = '0;
        data_d  = '0;
        if (!legal) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (misaligned) begin
          state_d     = SPLIT;
          mem_read_d  = !bus.req_write;
          mem_write_d = bus.req_write;
          mem_addr_d  = bus.req_addr;
          mem_wdata_d = {24'h0, bus.req_wdata[7:0]};
        end else begin
          state_d     = ACCESS;
          mem_read_d  = !bus.req_write;
          mem_write_d = bus.req_write;
          mem_func3_d = bus.req_func3;
          mem_addr_d  = bus.req_addr;
          mem_wdata_d = bus.req_wdata;
        end
      end
      ACCESS: begin
        state_d     = DONE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = write_q ? 32'h0 : extend(func3_q, bus.mem_rdata);
      end
      SPLIT: begin
        data_d = asm_data;
        if (idx_q == last_idx) begin
          state_d     = DONE;
          idx_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? 32'h0 : extend(func3_q, asm_data);
        end else begin
          // Present the next byte op now so mem_* stay registered outputs
          idx_d       = idx_nx;
          mem_read_d  = !write_q;
          mem_write_d = write_q;
          mem_addr_d  = addr_q + ADDR_W'(idx_nx);
          mem_wdata_d = {24'h0, wdata_q[{idx_nx, 3'b000} +: 8]};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      write_q     <= 1'b0;
      func3_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_func3_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      func3_q     <= func3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_func3_q <= mem_func3_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_func3 = mem_func3_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule
